// File: rtl/instr_encoder_if.sv
// Request and instruction-memory bus for instr_encoder.
// slave: encoder side; master: requester / memory model side.
interface instr_encoder_if;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  kind;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [5:0]  funct;
   logic [15:0] imm;
   logic [25:0] target;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wd;
   logic        mem_ready;

   modport slave (
      input  in_valid,
      input  kind,
      input  rs,
      input  rt,
      input  rd,
      input  funct,
      input  imm,
      input  target,
      input  mem_ready,
      output in_ready,
      output mem_we,
      output mem_addr,
      output mem_wd
   );

   modport master (
      output in_valid,
      output kind,
      output rs,
      output rt,
      output rd,
      output funct,
      output imm,
      output target,
      output mem_ready,
      input  in_ready,
      input  mem_we,
      input  mem_addr,
      input  mem_wd
   );
endinterface

// File: rtl/instr_encoder.sv
// MIPS-style instruction encoder feeding a 4-deep write FIFO
// that streams encoded words into instruction memory.
// Ports: clk, reset (sync, active-high); bus (instr_encoder_if.slave):
//   request in_valid/in_ready + fields, memory mem_we/mem_addr/mem_wd/
//   mem_ready; addr_set/base_addr load the write address;
//   err_illegal sticky flag; fifo_level occupancy 0-4.
// Option: define ENCODER_WCOUNT_EN to add word_count[15:0], a count
//   of completed writes cleared by addr_set.
module instr_encoder (
   input  logic             clk,
   input  logic             reset,
   instr_encoder_if.slave   bus,
   input  logic             addr_set,
   input  logic [31:0]      base_addr,
   output logic             err_illegal,
   output logic [2:0]       fifo_level
`ifdef ENCODER_WCOUNT_EN
   ,
   output logic [15:0]      word_count
`endif
);

   localparam logic [3:0] K_RTYPE = 4'd0;
   localparam logic [3:0] K_LW    = 4'd1;
   localparam logic [3:0] K_SW    = 4'd2;
   localparam logic [3:0] K_BEQ   = 4'd3;
   localparam logic [3:0] K_ADDI  = 4'd4;
   localparam logic [3:0] K_J     = 4'd5;
   localparam logic [3:0] K_BNE   = 4'd6;
   localparam logic [3:0] K_ORI   = 4'd7;
   localparam logic [3:0] K_ANDI  = 4'd8;
   localparam logic [3:0] K_SLTI  = 4'd9;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_SLTI  = 6'b001010;

   logic [31:0] enc_word;
   logic        enc_legal;

   logic [31:0] fifo_q [4];
   logic [1:0]  wr_ptr;
   logic [1:0]  rd_ptr;
   logic [2:0]  level_q;
   logic [31:0] addr_q;
   logic        err_q;

   logic        full;
   logic        empty;
   logic        accept;
   logic        push;
   logic        pop;
   logic [31:0] base_aligned;

   function automatic logic [31:0] itype(
      input logic [5:0]  op,
      input logic [4:0]  s,
      input logic [4:0]  t,
      input logic [15:0] im
   );
      return {op, s, t, im};
   endfunction

   always_comb begin
      enc_word  = 32'd0;
      enc_legal = 1'b1;
      case (bus.kind)
         K_RTYPE: enc_word = {OP_RTYPE, bus.rs, bus.rt,
                              bus.rd, 5'd0, bus.funct};
         K_LW:    enc_word = itype(OP_LW, bus.rs,
                                   bus.rt, bus.imm);
         K_SW:    enc_word = itype(OP_SW, bus.rs,
                                   bus.rt, bus.imm);
         K_BEQ:   enc_word = itype(OP_BEQ, bus.rs,
                                   bus.rt, bus.imm);
         K_ADDI:  enc_word = itype(OP_ADDI, bus.rs,
                                   bus.rt, bus.imm);
         K_J:     enc_word = {OP_J, bus.target};
         K_BNE:   enc_word = itype(OP_BNE, bus.rs,
                                   bus.rt, bus.imm);
         K_ORI:   enc_word = itype(OP_ORI, bus.rs,
                                   bus.rt, bus.imm);
         K_ANDI:  enc_word = itype(OP_ANDI, bus.rs,
                                   bus.rt, bus.imm);
         K_SLTI:  enc_word = itype(OP_SLTI, bus.rs,
                                   bus.rt, bus.imm);
         default: enc_legal = 1'b0;
      endcase
   end

   assign full  = (level_q == 3'd4);
   assign empty = (level_q == 3'd0);

   // in_ready depends only on registered fullness, so a pop in the
   // same cycle cannot reopen the input.
   assign bus.in_ready = !full && !reset;
   assign accept       = bus.in_valid && bus.in_ready;
   assign push         = accept && enc_legal;

   // Masking with reset keeps a queued word from looking written
   // in the cycle that discards it.
   assign bus.mem_we   = !empty && !reset;
   assign pop          = bus.mem_we && bus.mem_ready;

   assign bus.mem_wd   = fifo_q[rd_ptr];
   assign bus.mem_addr = addr_q;
   assign base_aligned = base_addr & 32'hFFFF_FFFC;
   assign err_illegal  = err_q;
   assign fifo_level   = level_q;

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_q[wr_ptr] <= enc_word;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr  <= 2'd0;
         rd_ptr  <= 2'd0;
         level_q <= 3'd0;
         addr_q  <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 2'd1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 2'd1;
         end
         case ({push, pop})
            2'b10:   level_q <= level_q + 3'd1;
            2'b01:   level_q <= level_q - 3'd1;
            default: level_q <= level_q;
         endcase
         // A load wins over the increment; the completing write
         // already used the old address on the bus.
         if (addr_set) begin
            addr_q <= base_aligned;
         end else if (pop) begin
            addr_q <= addr_q + 32'd4;
         end
         if (accept && !enc_legal) begin
            err_q <= 1'b1;
         end
      end
   end

`ifdef ENCODER_WCOUNT_EN
   logic [15:0] wcount_q;

   assign word_count = wcount_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         wcount_q <= 16'd0;
      end else if (addr_set) begin
         wcount_q <= 16'd0;
      end else if (pop) begin
         wcount_q <= wcount_q + 16'd1;
      end
   end
`endif

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have exactly one clock and a synchronous, active-high reset, named clk and reset as elsewhere in the codebase.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  instruction request present.
REQ-005 in_ready  output  1  request accepted this cycle when in_valid && in_ready.
REQ-006 kind  input  4  0 RTYPE, 1 LW, 2 SW, 3 BEQ, 4 ADDI, 5 J, 6 BNE, 7 ORI, 8 ANDI, 9 SLTI; 10-15 illegal.
REQ-007 rs, rt, rd  input  5 each  register fields.
REQ-008 funct  input  6  RTYPE function field.
REQ-009 imm  input  16  I-type immediate, emitted unmodified.
REQ-010 target  input  26  J-type word target.
REQ-011 addr_set  input  1  one-cycle pulse; loads the write address from base_addr.
REQ-012 base_addr  input  32  byte address; bits [1:0] ignored, forced to 0.
REQ-013 mem_we  output  1  write request to instruction memory.
REQ-014 mem_addr  output  32  byte address of the current write.
REQ-015 mem_wd  output  32  encoded machine word.
REQ-016 mem_ready  input  1  memory accepts the write this cycle.
REQ-017 err_illegal  output  1  sticky flag: an illegal kind was accepted.
REQ-018 fifo_level  output  3  occupancy, 0-4.

Function
REQ-019 Encoding SHALL be RTYPE {000000,rs,rt,rd,00000,funct}; I-type {op,rs,rt,imm}; J {000010,target}.
REQ-020 I-type opcodes SHALL be LW 100011, SW 101011, BEQ 000100, ADDI 001000, BNE 000101, ORI 001101, ANDI 001100, SLTI 001010.
REQ-021 Encoding SHALL be combinational from the inputs; the encoded word is pushed into a 4-entry FIFO on acceptance.
REQ-022 in_ready SHALL equal !full. A pop in the same cycle SHALL NOT raise in_ready in that cycle.
REQ-023 An accepted illegal kind SHALL NOT be pushed; err_illegal SHALL set the next cycle and hold until reset.
REQ-024 mem_we SHALL equal !empty. mem_wd SHALL be the FIFO head and mem_addr the address register.
REQ-025 A write completes when mem_we && mem_ready: pop, and mem_addr += 4, wrapping modulo 2^32.
REQ-026 mem_wd and mem_addr SHALL remain stable while mem_we is high and mem_ready is low.
REQ-027 Simultaneous push and pop SHALL leave fifo_level unchanged and preserve order.
REQ-028 Latency SHALL be one cycle: a word accepted at edge N appears on mem_wd after edge N if the FIFO was empty.
REQ-029 When addr_set is high, the next mem_addr SHALL be {base_addr[31:2],2'b00}. This overrides the increment; a write completing in that same cycle uses the old address.

Reset
REQ-030 On reset, FIFO pointers and fifo_level SHALL be 0, mem_we 0, mem_addr 0, and err_illegal 0.
REQ-031 While reset is high, in_ready SHALL be 0.
REQ-032 A reset during pending writes SHALL discard all queued words; no write completes in the reset cycle.

Configuration
REQ-033 With ENCODER_WCOUNT_EN defined, the block SHALL add output word_count [15:0]. It is reset to 0, increments on each completed write, wraps at 0xFFFF, and is cleared by addr_set.
REQ-034 Without ENCODER_WCOUNT_EN, the word_count port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-035 reset, then kind=4 (ADDI), rs=0, rt=8, imm=5, mem_ready=1 -> mem_we=1, mem_wd=0x20080005, mem_addr=0x00000000, then 0x4.
REQ-036 kind=0, rs=17, rt=18, rd=16, funct=0x20 -> mem_wd=0x02328020; kind=5, target=0x0000010 -> mem_wd=0x08000010.
REQ-037 mem_ready=0, five back-to-back valid BNE requests (rs=1, rt=2, imm=0xFFFF) -> four accepted, fifo_level=4, in_ready=0. Then mem_ready=1 -> four writes of 0x1422FFFF at consecutive addresses.
REQ-038 kind=12 -> nothing written, err_illegal=1 next cycle; a following legal ORI is written normally and err_illegal stays 1.
REQ-039 addr_set with base_addr=0x00400003 in the cycle a write completes at 0x8 -> that write goes to 0x8, the next to 0x00400000. Reset with 3 words queued -> mem_we=0 and fifo_level=0 next cycle.
